// File: rtl/mul_tree_arb.sv
// mul_tree_arb: shares one mul_tree_bf16 between NREQ requesters.
// Round-robin grants issue one operand set per cycle into the tree. A mode
// change waits for the pipeline to drain before the tree mode register
// moves. An in-order tag FIFO routes each tree result back to its owner.
module mul_tree_arb #(
  parameter int NREQ    = 4,
  parameter int DW      = 16,
  parameter int IW      = 32,
  parameter int MAX_OUT = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*4*IW-1:0]   req_ins,
  input  logic [NREQ*2-1:0]      req_mode,
  output logic [4*IW-1:0]        mul_ins,
  output logic                   mul_stb,
  output logic [1:0]             mode,
  input  logic [4*DW-1:0]        tree_outputs,
  input  logic [3:0]             tree_stbs,
  output logic [NREQ-1:0]        rsp_valid,
  output logic [4*DW-1:0]        rsp_data,
  output logic [3:0]             rsp_lanes,
  output logic                   busy,
  output logic                   err_orphan
);

  localparam int TW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(MAX_OUT + 1);
  localparam int AW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam logic [NREQ-1:0] ONE_S = {{(NREQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_ISSUE  = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_SWITCH = 2'd2
  } state_t;

  state_t            state_r, state_next_s;
  logic [TW-1:0]     ptr_r;
  logic [TW-1:0]     lock_r, lock_next_s;
  logic              first_r;
  logic [CW-1:0]     out_r, out_next_s;
  logic [AW-1:0]     wr_r, rd_r;
  logic [TW-1:0]     tag_mem_r [MAX_OUT];
  logic [1:0]        mode_r;
  logic [4*IW-1:0]   mul_ins_r;
  logic              mul_stb_r;
  logic [NREQ-1:0]   rsp_valid_r;
  logic [4*DW-1:0]   rsp_data_r;
  logic [3:0]        rsp_lanes_r;
  logic              busy_r;
  logic              err_orphan_r;

  logic [TW-1:0]     scan_idx_s;
  logic [TW-1:0]     cand_s;
  logic              found_s;
  logic              lock_hit_s;
  logic [1:0]        cand_mode_s;
  logic              mode_ok_s;
  logic              room_s;
  logic              hs_s;
  logic              ret_s;
  logic              orphan_s;

  // Pick the round-robin candidate; right after a mode switch the locked requester wins.
  always_comb begin
    found_s    = 1'b0;
    cand_s     = ptr_r;
    scan_idx_s = ptr_r;
    for (int k = 1; k <= NREQ; k++) begin
      scan_idx_s = TW'((int'(ptr_r) + k) % NREQ);
      cand_s     = (req_valid[scan_idx_s] && !found_s) ? scan_idx_s : cand_s;
      found_s    = found_s | req_valid[scan_idx_s];
    end
    lock_hit_s  = first_r & req_valid[lock_r];
    cand_s      = lock_hit_s ? lock_r : cand_s;
    found_s     = found_s | lock_hit_s;
    cand_mode_s = req_mode[int'(cand_s)*2 +: 2];
  end

  // Grant, retire and outstanding-count decisions for this cycle.
  always_comb begin
    mode_ok_s  = (cand_mode_s == mode_r);
    room_s     = (out_r < CW'(MAX_OUT));
    hs_s       = (state_r == ST_ISSUE) && found_s && mode_ok_s && room_s;
    ret_s      = (tree_stbs != 4'b0000) && (out_r != {CW{1'b0}});
    orphan_s   = (tree_stbs != 4'b0000) && (out_r == {CW{1'b0}});
    out_next_s = out_r + CW'(hs_s) - CW'(ret_s);
    if (hs_s) begin
      req_ready = ONE_S << cand_s;
    end else begin
      req_ready = {NREQ{1'b0}};
    end
  end

  // Next-state logic: a mode mismatch drains the pipeline, then one switch cycle.
  always_comb begin
    state_next_s = state_r;
    lock_next_s  = lock_r;
    case (state_r)
      ST_ISSUE: begin
        if (found_s && !mode_ok_s) begin
          state_next_s = ST_DRAIN;
          lock_next_s  = cand_s;
        end else begin
          state_next_s = ST_ISSUE;
        end
      end
      ST_DRAIN: begin
        if (out_next_s == {CW{1'b0}}) begin
          state_next_s = ST_SWITCH;
        end else begin
          state_next_s = ST_DRAIN;
        end
      end
      ST_SWITCH: state_next_s = ST_ISSUE;
      default:   state_next_s = ST_ISSUE;
    endcase
  end

  // Control state: FSM, RR pointer, outstanding count, tag FIFO and mode register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_ISSUE;
      ptr_r        <= TW'(NREQ - 1);
      lock_r       <= {TW{1'b0}};
      first_r      <= 1'b0;
      out_r        <= {CW{1'b0}};
      wr_r         <= {AW{1'b0}};
      rd_r         <= {AW{1'b0}};
      mode_r       <= 2'b00;
      busy_r       <= 1'b0;
      err_orphan_r <= 1'b0;
      for (int i = 0; i < MAX_OUT; i++) begin
        tag_mem_r[i] <= {TW{1'b0}};
      end
    end else begin
      state_r <= state_next_s;
      lock_r  <= lock_next_s;
      first_r <= (state_r == ST_SWITCH);
      out_r   <= out_next_s;
      busy_r  <= (out_next_s != {CW{1'b0}}) || (state_next_s != ST_ISSUE);
      if (hs_s) begin
        ptr_r           <= cand_s;
        tag_mem_r[wr_r] <= cand_s;
        wr_r            <= wr_r + AW'(1);
      end
      if (ret_s) begin
        rd_r <= rd_r + AW'(1);
      end
      if (state_r == ST_SWITCH) begin
        mode_r <= req_mode[int'(lock_r)*2 +: 2];
      end
      if (orphan_s) begin
        err_orphan_r <= 1'b1;
      end
    end
  end

  // Datapath registers: operand issue toward the tree and result return to requesters.
  always_ff @(posedge clk) begin
    if (rst) begin
      mul_ins_r   <= {(4*IW){1'b0}};
      mul_stb_r   <= 1'b0;
      rsp_valid_r <= {NREQ{1'b0}};
      rsp_data_r  <= {(4*DW){1'b0}};
      rsp_lanes_r <= 4'b0000;
    end else begin
      mul_stb_r <= hs_s;
      if (hs_s) begin
        mul_ins_r <= req_ins[int'(cand_s)*4*IW +: 4*IW];
      end
      if (ret_s) begin
        rsp_valid_r <= ONE_S << tag_mem_r[rd_r];
        rsp_data_r  <= tree_outputs;
        rsp_lanes_r <= tree_stbs;
      end else begin
        rsp_valid_r <= {NREQ{1'b0}};
      end
    end
  end

  assign mul_ins    = mul_ins_r;
  assign mul_stb    = mul_stb_r;
  assign mode       = mode_r;
  assign rsp_valid  = rsp_valid_r;
  assign rsp_data   = rsp_data_r;
  assign rsp_lanes  = rsp_lanes_r;
  assign busy       = busy_r;
  assign err_orphan = err_orphan_r;

endmodule

// File: tb/tb_mul_tree_arb.sv
// Bench for mul_tree_arb: the bench plays requesters and the multiplier tree.
// Expected issues and responses go into queues; a negedge monitor pops them.
module tb_mul_tree_arb;

  localparam int NREQ    = 4;
  localparam int DW      = 16;
  localparam int IW      = 32;
  localparam int MAX_OUT = 8;

  logic                 clk;
  logic                 rst;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*4*IW-1:0] req_ins;
  logic [NREQ*2-1:0]    req_mode;
  logic [4*IW-1:0]      mul_ins;
  logic                 mul_stb;
  logic [1:0]           mode;
  logic [4*DW-1:0]      tree_outputs;
  logic [3:0]           tree_stbs;
  logic [NREQ-1:0]      rsp_valid;
  logic [4*DW-1:0]      rsp_data;
  logic [3:0]           rsp_lanes;
  logic                 busy;
  logic                 err_orphan;

  mul_tree_arb #(.NREQ(NREQ), .DW(DW), .IW(IW), .MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_ins(req_ins), .req_mode(req_mode),
    .mul_ins(mul_ins), .mul_stb(mul_stb), .mode(mode),
    .tree_outputs(tree_outputs), .tree_stbs(tree_stbs),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_lanes(rsp_lanes),
    .busy(busy), .err_orphan(err_orphan)
  );

  typedef struct packed {
    logic [NREQ-1:0] v;
    logic [4*DW-1:0] d;
    logic [3:0]      l;
  } rsp_t;

  rsp_t            rsp_q[$];
  logic [4*IW-1:0] issue_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [4*IW-1:0] ops(input int r, input int n);
    logic [31:0] w;
    w = 32'h3F80_0000 + 32'(r * 16 + n);
    return {4{w}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // Bench acts as the tree: present one result and record who should get it.
  task automatic tree_ret(input logic [3:0] owner, input logic [63:0] d, input logic [3:0] l);
    rsp_t e;
    tree_outputs = d;
    tree_stbs    = l;
    e.v = owner;
    e.d = d;
    e.l = l;
    rsp_q.push_back(e);
  endtask

  task automatic do_reset();
    req_valid = 4'b0000;
    tree_stbs = 4'b0000;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Scoreboard monitor: every DUT issue/response must match the head of its queue.
  always @(negedge clk) begin
    rsp_t e;
    if (rsp_valid !== 4'b0000) begin
      if (rsp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rsp_unexpected: got valid=%b data=%h, expected no response", rsp_valid, rsp_data);
      end else begin
        e = rsp_q.pop_front();
        check("rsp_valid", 128'(rsp_valid), 128'(e.v));
        check("rsp_data",  128'(rsp_data),  128'(e.d));
        check("rsp_lanes", 128'(rsp_lanes), 128'(e.l));
      end
    end
    if (mul_stb === 1'b1) begin
      if (issue_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL issue_unexpected: got mul_stb with mul_ins=%h, expected no issue", mul_ins);
      end else begin
        check("mul_ins", mul_ins, issue_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req_valid = 4'b0000; req_ins = '0; req_mode = 8'h00;
    tree_outputs = 64'h0; tree_stbs = 4'b0000;
    tick();
    mid();
    check("rst_mul_stb",   128'(mul_stb),   128'(0));
    check("rst_mul_ins",   mul_ins,         128'(0));
    check("rst_mode",      128'(mode),      128'(0));
    check("rst_rsp_valid", 128'(rsp_valid), 128'(0));
    check("rst_rsp_data",  128'(rsp_data),  128'(0));
    check("rst_busy",      128'(busy),      128'(0));
    check("rst_err",       128'(err_orphan),128'(0));
    tick();
    rst = 1'b0;

    // Test 1: single requester, one op, one response.
    req_ins[0 +: 128] = {4{32'h3F80_3F80}};
    issue_q.push_back({4{32'h3F80_3F80}});
    req_valid = 4'b0001;
    mid();
    check("t1_ready", 128'(req_ready), 128'(4'b0001));
    tick();
    req_valid = 4'b0000;
    mid();
    check("t1_busy", 128'(busy), 128'(1));
    tick();
    tree_ret(4'b0001, {4{16'h3F80}}, 4'b1111);
    tick();
    tree_stbs = 4'b0000;
    tick();
    mid();
    check("t1_idle", 128'(busy), 128'(0));
    check("t1_rsp_done", 128'(rsp_q.size()), 128'(0));

    // Test 2: all requesters continuously valid -> 0,1,2,3,0,1,2,3 then FIFO full.
    tick();
    do_reset();
    for (int r = 0; r < NREQ; r++) req_ins[r*128 +: 128] = ops(r, 2);
    for (int k = 0; k < 8; k++) issue_q.push_back(ops(k % 4, 2));
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      mid();
      check("t2_grant", 128'(req_ready), 128'(4'b0001 << (k % 4)));
      tick();
    end
    mid();
    check("t2_full_stall", 128'(req_ready), 128'(0));
    tick();
    req_valid = 4'b0000;
    for (int j = 0; j < 8; j++) begin
      tree_ret(4'b0001 << (j % 4), {4{16'(16'h4000 + j)}}, (j % 2 == 1) ? 4'b1111 : 4'b0011);
      tick();
    end
    tree_stbs = 4'b0000;
    tick(); tick();
    check("t2_rsp_done", 128'(rsp_q.size()), 128'(0));

    // Test 3: results withheld -> exactly MAX_OUT grants; retire reopens; issue+retire holds count.
    do_reset();
    req_ins[2*128 +: 128] = ops(2, 3);
    for (int k = 0; k < 10; k++) issue_q.push_back(ops(2, 3));
    req_valid = 4'b0100;
    for (int k = 0; k < 8; k++) begin
      mid();
      check("t3_grant", 128'(req_ready), 128'(4'b0100));
      tick();
    end
    mid();
    check("t3_stall", 128'(req_ready), 128'(0));
    tick();
    mid();
    check("t3_stall2", 128'(req_ready), 128'(0));
    tick();
    tree_ret(4'b0100, 64'h1111_2222_3333_4444, 4'b0001);
    mid();
    check("t3_full_retire", 128'(req_ready), 128'(0));
    tick();
    tree_ret(4'b0100, 64'h5555_6666_7777_8888, 4'b0001);
    mid();
    check("t3_reopen", 128'(req_ready), 128'(4'b0100));
    tick();
    tree_stbs = 4'b0000;
    mid();
    check("t3_issue_retire_keeps", 128'(req_ready), 128'(4'b0100));
    tick();
    mid();
    check("t3_full_again", 128'(req_ready), 128'(0));
    tick();
    req_valid = 4'b0000;
    for (int j = 0; j < 8; j++) begin
      tree_ret(4'b0100, {4{16'(16'h5000 + j)}}, 4'b1000);
      tick();
    end
    tree_stbs = 4'b0000;
    tick(); tick();
    check("t3_rsp_done", 128'(rsp_q.size()), 128'(0));

    // Test 4: mode change waits for 3 in-flight ops, one switch cycle, then locked grant.
    do_reset();
    req_ins[0 +: 128]   = ops(0, 4);
    req_ins[128 +: 128] = ops(1, 4);
    req_mode = 8'b0000_0100;
    for (int k = 0; k < 3; k++) issue_q.push_back(ops(0, 4));
    req_valid = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      mid();
      check("t4_grant0", 128'(req_ready), 128'(4'b0001));
      tick();
    end
    req_valid = 4'b0010;
    mid();
    check("t4_mismatch_ready", 128'(req_ready), 128'(0));
    tick();
    tree_ret(4'b0001, 64'hAAAA_0001_AAAA_0001, 4'b1111);
    mid();
    check("t4_drain_ready", 128'(req_ready), 128'(0));
    check("t4_drain_mode",  128'(mode),      128'(0));
    check("t4_drain_busy",  128'(busy),      128'(1));
    tick();
    tree_stbs = 4'b0000;
    mid();
    check("t4_drain_nostb", 128'(mul_stb), 128'(0));
    tick();
    tree_ret(4'b0001, 64'hAAAA_0002_AAAA_0002, 4'b0101);
    mid();
    check("t4_drain_ready2", 128'(req_ready), 128'(0));
    tick();
    tree_ret(4'b0001, 64'hAAAA_0003_AAAA_0003, 4'b1010);
    mid();
    check("t4_drain_mode2", 128'(mode), 128'(0));
    tick();
    tree_stbs = 4'b0000;
    issue_q.push_back(ops(1, 4));
    mid();
    check("t4_switch_ready", 128'(req_ready), 128'(0));
    check("t4_switch_mode",  128'(mode),      128'(0));
    tick();
    mid();
    check("t4_mode_new",   128'(mode),      128'(2'b01));
    check("t4_lock_grant", 128'(req_ready), 128'(4'b0010));
    tick();
    req_valid = 4'b0000;
    tick();
    tree_ret(4'b0010, 64'hBBBB_0004_BBBB_0004, 4'b0001);
    tick();
    tree_stbs = 4'b0000;
    tick(); tick();
    check("t4_rsp_done", 128'(rsp_q.size()), 128'(0));

    // Test 5: result with empty FIFO -> dropped, sticky error.
    tree_outputs = 64'hDEAD_BEEF_DEAD_BEEF;
    tree_stbs = 4'b1111;
    tick();
    tree_stbs = 4'b0000;
    mid();
    check("t5_err_set", 128'(err_orphan), 128'(1));
    check("t5_no_rsp",  128'(rsp_valid),  128'(0));
    tick(); tick(); tick();
    mid();
    check("t5_err_sticky", 128'(err_orphan), 128'(1));
    tick();

    // Test 6: reset with 5 outstanding in mode 01 clears everything.
    req_ins[3*128 +: 128] = ops(3, 6);
    req_mode = 8'b0100_0100;
    for (int k = 0; k < 5; k++) issue_q.push_back(ops(3, 6));
    req_valid = 4'b1000;
    for (int k = 0; k < 5; k++) begin
      mid();
      check("t6_grant", 128'(req_ready), 128'(4'b1000));
      tick();
    end
    rst = 1'b1;
    req_valid = 4'b0000;
    mid();
    check("t6_busy_before", 128'(busy), 128'(1));
    tick();
    mid();
    check("t6_busy",      128'(busy),       128'(0));
    check("t6_mode",      128'(mode),       128'(0));
    check("t6_mul_stb",   128'(mul_stb),    128'(0));
    check("t6_mul_ins",   mul_ins,          128'(0));
    check("t6_rsp_valid", 128'(rsp_valid),  128'(0));
    check("t6_rsp_data",  128'(rsp_data),   128'(0));
    check("t6_rsp_lanes", 128'(rsp_lanes),  128'(0));
    check("t6_err",       128'(err_orphan), 128'(0));
    check("t6_ready",     128'(req_ready),  128'(0));
    tick();
    rst = 1'b0;
    tick(); tick(); tick();
    mid();
    check("t6_idle_busy", 128'(busy),       128'(0));
    check("t6_no_orphan", 128'(err_orphan), 128'(0));
    check("end_issue_q",  128'(issue_q.size()), 128'(0));
    check("end_rsp_q",    128'(rsp_q.size()),   128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
